// File: rtl/axi_arbiter.sv
// Two-master (icache read-only, LSU read/write) to one-slave AXI4 arbiter.
// One transaction in flight; alternating grant under contention, LSU wins an idle tie.
module axi_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n_sync,
  // icache read
  input  logic [ADDR_WIDTH-1:0]   ic_araddr,
  input  logic                    ic_arvalid,
  input  logic [3:0]              ic_arid,
  input  logic [7:0]              ic_arlen,
  input  logic [2:0]              ic_arsize,
  input  logic [1:0]              ic_arburst,
  output logic                    ic_arready,
  output logic [DATA_WIDTH-1:0]   ic_rdata,
  output logic [1:0]              ic_rresp,
  output logic                    ic_rvalid,
  output logic                    ic_rlast,
  output logic [3:0]              ic_rid,
  input  logic                    ic_rready,
  // LSU read
  input  logic [ADDR_WIDTH-1:0]   lsu_araddr,
  input  logic                    lsu_arvalid,
  input  logic [3:0]              lsu_arid,
  input  logic [7:0]              lsu_arlen,
  input  logic [2:0]              lsu_arsize,
  input  logic [1:0]              lsu_arburst,
  output logic                    lsu_arready,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic [1:0]              lsu_rresp,
  output logic                    lsu_rvalid,
  output logic                    lsu_rlast,
  output logic [3:0]              lsu_rid,
  input  logic                    lsu_rready,
  // LSU write
  input  logic [ADDR_WIDTH-1:0]   lsu_awaddr,
  input  logic                    lsu_awvalid,
  input  logic [3:0]              lsu_awid,
  input  logic [7:0]              lsu_awlen,
  input  logic [2:0]              lsu_awsize,
  input  logic [1:0]              lsu_awburst,
  output logic                    lsu_awready,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
  input  logic                    lsu_wvalid,
  input  logic                    lsu_wlast,
  output logic                    lsu_wready,
  output logic [1:0]              lsu_bresp,
  output logic                    lsu_bvalid,
  output logic [3:0]              lsu_bid,
  input  logic                    lsu_bready,
  // master port toward the crossbar
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  output logic [3:0]              m_axi_awid,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  input  logic [3:0]              m_axi_bid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  output logic [3:0]              m_axi_arid,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  input  logic                    m_axi_rlast,
  input  logic [3:0]              m_axi_rid,
  output logic                    m_axi_rready
);

  typedef enum logic [1:0] {IDLE, RD_IC, RD_LSU, WR_LSU} state_t;

  state_t state, state_nxt;
  logic   last_lsu, last_lsu_nxt;
  logic   addr_done, addr_done_nxt;
  logic   rd_ic, rd_lsu, wr_lsu;

  assign rd_ic  = (state == RD_IC);
  assign rd_lsu = (state == RD_LSU);
  assign wr_lsu = (state == WR_LSU);

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      state     <= IDLE;
      last_lsu  <= 1'b0;
      addr_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_lsu  <= last_lsu_nxt;
      addr_done <= addr_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_lsu_nxt  = last_lsu;
    addr_done_nxt = addr_done;
    case (state)
      IDLE: begin
        addr_done_nxt = 1'b0;
        // icache wins only if alone or if the LSU had the previous grant
        if (ic_arvalid && (!(lsu_awvalid || lsu_arvalid) || last_lsu)) begin
          state_nxt    = RD_IC;
          last_lsu_nxt = 1'b0;
        end else if (lsu_awvalid) begin
          state_nxt    = WR_LSU;
          last_lsu_nxt = 1'b1;
        end else if (lsu_arvalid) begin
          state_nxt    = RD_LSU;
          last_lsu_nxt = 1'b1;
        end
      end
      RD_IC, RD_LSU: begin
        if (m_axi_arvalid && m_axi_arready) addr_done_nxt = 1'b1;
        if (m_axi_rvalid && m_axi_rready && m_axi_rlast) state_nxt = IDLE;
      end
      WR_LSU: begin
        if (m_axi_awvalid && m_axi_awready) addr_done_nxt = 1'b1;
        if (m_axi_bvalid && m_axi_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // read address and data routing
  assign m_axi_arvalid = !addr_done && ((rd_ic && ic_arvalid) || (rd_lsu && lsu_arvalid));
  assign ic_arready    = rd_ic  && !addr_done && m_axi_arready;
  assign lsu_arready   = rd_lsu && !addr_done && m_axi_arready;
  assign m_axi_araddr  = rd_ic ? ic_araddr  : (rd_lsu ? lsu_araddr  : '0);
  assign m_axi_arid    = rd_ic ? ic_arid    : (rd_lsu ? lsu_arid    : '0);
  assign m_axi_arlen   = rd_ic ? ic_arlen   : (rd_lsu ? lsu_arlen   : '0);
  assign m_axi_arsize  = rd_ic ? ic_arsize  : (rd_lsu ? lsu_arsize  : '0);
  assign m_axi_arburst = rd_ic ? ic_arburst : (rd_lsu ? lsu_arburst : '0);
  assign m_axi_rready  = (rd_ic && ic_rready) || (rd_lsu && lsu_rready);

  assign ic_rvalid  = rd_ic && m_axi_rvalid;
  assign ic_rdata   = rd_ic ? m_axi_rdata : '0;
  assign ic_rresp   = rd_ic ? m_axi_rresp : '0;
  assign ic_rlast   = rd_ic && m_axi_rlast;
  assign ic_rid     = rd_ic ? m_axi_rid   : '0;
  assign lsu_rvalid = rd_lsu && m_axi_rvalid;
  assign lsu_rdata  = rd_lsu ? m_axi_rdata : '0;
  assign lsu_rresp  = rd_lsu ? m_axi_rresp : '0;
  assign lsu_rlast  = rd_lsu && m_axi_rlast;
  assign lsu_rid    = rd_lsu ? m_axi_rid   : '0;

  // write routing: AW and W are independent, B closes the transaction
  assign m_axi_awvalid = wr_lsu && !addr_done && lsu_awvalid;
  assign lsu_awready   = wr_lsu && !addr_done && m_axi_awready;
  assign m_axi_awaddr  = wr_lsu ? lsu_awaddr  : '0;
  assign m_axi_awid    = wr_lsu ? lsu_awid    : '0;
  assign m_axi_awlen   = wr_lsu ? lsu_awlen   : '0;
  assign m_axi_awsize  = wr_lsu ? lsu_awsize  : '0;
  assign m_axi_awburst = wr_lsu ? lsu_awburst : '0;
  assign m_axi_wvalid  = wr_lsu && lsu_wvalid;
  assign lsu_wready    = wr_lsu && m_axi_wready;
  assign m_axi_wdata   = wr_lsu ? lsu_wdata : '0;
  assign m_axi_wstrb   = wr_lsu ? lsu_wstrb : '0;
  assign m_axi_wlast   = wr_lsu && lsu_wlast;
  assign m_axi_bready  = wr_lsu && lsu_bready;
  assign lsu_bvalid    = wr_lsu && m_axi_bvalid;
  assign lsu_bresp     = wr_lsu ? m_axi_bresp : '0;
  assign lsu_bid       = wr_lsu ? m_axi_bid   : '0;

endmodule

// File: tb/tb_axi_arbiter.sv
// Scoreboard bench for axi_arbiter: a small AXI slave model answers on m_axi,
// stimulus pushes expected handshakes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_axi_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n_sync;

  logic [31:0] ic_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
  logic        ic_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, lsu_wlast;
  logic [3:0]  ic_arid, lsu_arid, lsu_awid, lsu_wstrb;
  logic [7:0]  ic_arlen, lsu_arlen, lsu_awlen;
  logic [2:0]  ic_arsize, lsu_arsize, lsu_awsize;
  logic [1:0]  ic_arburst, lsu_arburst, lsu_awburst;
  logic        ic_rready, lsu_rready, lsu_bready;
  logic        ic_arready, lsu_arready, lsu_awready, lsu_wready;
  logic [31:0] ic_rdata, lsu_rdata;
  logic [1:0]  ic_rresp, lsu_rresp, lsu_bresp;
  logic        ic_rvalid, ic_rlast, lsu_rvalid, lsu_rlast, lsu_bvalid;
  logic [3:0]  ic_rid, lsu_rid, lsu_bid;

  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wlast, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [3:0]  m_axi_awid, m_axi_wstrb, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;

  axi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n_sync(rst_n_sync),
    .ic_araddr(ic_araddr), .ic_arvalid(ic_arvalid), .ic_arid(ic_arid), .ic_arlen(ic_arlen),
    .ic_arsize(ic_arsize), .ic_arburst(ic_arburst), .ic_arready(ic_arready),
    .ic_rdata(ic_rdata), .ic_rresp(ic_rresp), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
    .ic_rid(ic_rid), .ic_rready(ic_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rlast(lsu_rlast),
    .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wlast(lsu_wlast),
    .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bid(lsu_bid),
    .lsu_bready(lsu_bready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rid(m_axi_rid), .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cyc = -100;
  int err_beat = 255;
  logic slv_clr = 1'b0;
  logic [63:0] ar_q[$], aw_q[$], w_q[$], ic_q[$], lsu_q[$], b_q[$];
  int gap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] addr_t(logic [3:0] id, logic [31:0] a, logic [7:0] l);
    return {15'b0, id, a, l, 3'd2, 2'd1};
  endfunction

  function automatic logic [11:0] quiet();
    return {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready,
            ic_arready, ic_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid};
  endfunction

  // slave model: data = burst address + 4*beat, resp 2 on beat err_beat
  logic        rd_active, aw_got, w_got, bv;
  logic [31:0] s_addr;
  logic [7:0]  s_len, beat;
  logic [3:0]  s_id, s_bid;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
  initial begin
    rd_active = 0; aw_got = 0; w_got = 0; bv = 0;
    s_addr = 0; s_len = 0; beat = 0; s_id = 0; s_bid = 0;
    forever begin
      m_axi_arready = !rd_active;
      m_axi_rvalid  = rd_active;
      m_axi_rdata   = s_addr + {22'b0, beat, 2'b00};
      m_axi_rresp   = (int'(beat) == err_beat) ? 2'd2 : 2'd0;
      m_axi_rlast   = rd_active && (beat == s_len);
      m_axi_rid     = s_id;
      m_axi_awready = !aw_got;
      m_axi_wready  = !w_got;
      m_axi_bvalid  = bv;
      m_axi_bresp   = 2'd0;
      m_axi_bid     = s_bid;
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      if (ar_hs) begin s_addr = m_axi_araddr; s_len = m_axi_arlen; s_id = m_axi_arid; end
      if (aw_hs) s_bid = m_axi_awid;
      @(posedge clk); #1;
      if (slv_clr) begin
        rd_active = 0; aw_got = 0; w_got = 0; bv = 0; beat = 0;
      end else begin
        if (ar_hs) begin rd_active = 1; beat = 0; end
        else if (r_hs) begin
          if (beat == s_len) rd_active = 0;
          else beat = beat + 8'd1;
        end
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (b_hs) begin aw_got = 0; w_got = 0; bv = 0; end
        else if (aw_got && w_got) bv = 1;
      end
    end
  end

  // monitor
  initial begin
    logic [63:0] e;
    int g;
    forever begin
      @(negedge clk);
      if (m_axi_arvalid && m_axi_arready) begin
        if (ar_q.size() == 0) flag("ar_unexpected");
        else begin
          e = ar_q.pop_front(); g = gap_q.pop_front();
          chk("m_axi_ar", {15'b0, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}, e);
          if (g != 0) chk("ar_gap_after_done", 64'(cyc - done_cyc), 64'(g));
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_q.size() == 0) flag("aw_unexpected");
        else chk("m_axi_aw", {15'b0, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst}, aw_q.pop_front());
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_q.size() == 0) flag("w_unexpected");
        else chk("m_axi_w", {27'b0, m_axi_wdata, m_axi_wstrb, m_axi_wlast}, w_q.pop_front());
      end
      if (ic_rvalid && ic_rready) begin
        if (ic_q.size() == 0) flag("ic_r_unexpected");
        else chk("ic_r", {25'b0, ic_rdata, ic_rresp, ic_rlast, ic_rid}, ic_q.pop_front());
      end
      if (lsu_rvalid && lsu_rready) begin
        if (lsu_q.size() == 0) flag("lsu_r_unexpected");
        else chk("lsu_r", {25'b0, lsu_rdata, lsu_rresp, lsu_rlast, lsu_rid}, lsu_q.pop_front());
      end
      if (lsu_bvalid && lsu_bready) begin
        if (b_q.size() == 0) flag("lsu_b_unexpected");
        else chk("lsu_b", {58'b0, lsu_bresp, lsu_bid}, b_q.pop_front());
      end
      if (ic_rvalid) chk("lsu_r_quiet", {lsu_rvalid, lsu_rlast, lsu_rresp, lsu_rdata}, 64'd0);
      if (lsu_rvalid) chk("ic_r_quiet", {ic_rvalid, ic_rlast, ic_rresp, ic_rdata}, 64'd0);
      if ((m_axi_rvalid && m_axi_rready && m_axi_rlast) || (m_axi_bvalid && m_axi_bready))
        done_cyc = cyc;
    end
  end

  task automatic push_ic_beats(input logic [31:0] addr, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++)
      ic_q.push_back({25'b0, addr + 32'(i * 4), (i == err_beat) ? 2'd2 : 2'd0, i == int'(len), 4'h1});
  endtask

  task automatic ic_read(input logic [31:0] addr, input logic [7:0] len, input int stall_after);
    bit done;
    int beats;
    push_ic_beats(addr, len);
    ic_araddr = addr; ic_arlen = len; ic_arid = 4'h1; ic_arsize = 3'd2; ic_arburst = 2'd1;
    ic_arvalid = 1; ic_rready = 1;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin @(negedge clk); if (ic_arready) done = 1; end
    if (!done) flag("ic_ar_timeout");
    @(posedge clk); #1 ic_arvalid = 0;
    done = 0; beats = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (ic_rvalid && ic_rready) begin
        beats++;
        if (ic_rlast) done = 1;
        else if (beats == stall_after) begin
          @(posedge clk); #1 ic_rready = 0;
          repeat (3) @(posedge clk);
          #1 ic_rready = 1;
        end
      end
    end
    if (!done) flag("ic_rlast_timeout");
    @(posedge clk); #1;
  endtask

  task automatic lsu_read(input logic [31:0] addr);
    bit done;
    lsu_q.push_back({25'b0, addr, 2'd0, 1'b1, 4'h2});
    lsu_araddr = addr; lsu_arlen = 0; lsu_arid = 4'h2; lsu_arsize = 3'd2; lsu_arburst = 2'd1;
    lsu_arvalid = 1;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin @(negedge clk); if (lsu_arready) done = 1; end
    if (!done) flag("lsu_ar_timeout");
    @(posedge clk); #1 lsu_arvalid = 0;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin @(negedge clk); if (lsu_rvalid && lsu_rlast) done = 1; end
    if (!done) flag("lsu_rlast_timeout");
    @(posedge clk); #1;
  endtask

  task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data);
    bit done;
    aw_q.push_back(addr_t(4'h3, addr, 8'd0));
    w_q.push_back({27'b0, data, 4'hF, 1'b1});
    b_q.push_back({58'b0, 2'd0, 4'h3});
    lsu_awaddr = addr; lsu_awid = 4'h3; lsu_awlen = 0; lsu_awsize = 3'd2; lsu_awburst = 2'd1;
    lsu_awvalid = 1;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin @(negedge clk); if (lsu_awready) done = 1; end
    if (!done) flag("lsu_aw_timeout");
    @(posedge clk); #1 lsu_awvalid = 0;
    repeat (2) @(posedge clk);
    #1 lsu_wdata = data; lsu_wstrb = 4'hF; lsu_wlast = 1; lsu_wvalid = 1;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin @(negedge clk); if (lsu_wready) done = 1; end
    if (!done) flag("lsu_w_timeout");
    @(posedge clk); #1 lsu_wvalid = 0; lsu_wlast = 0;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin @(negedge clk); if (lsu_bvalid) done = 1; end
    if (!done) flag("lsu_b_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit done;
    int beats;
    rst_n_sync = 0;
    ic_araddr = 0; ic_arvalid = 0; ic_arid = 0; ic_arlen = 0; ic_arsize = 0; ic_arburst = 0;
    lsu_araddr = 0; lsu_arvalid = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_arburst = 0;
    lsu_awaddr = 0; lsu_awvalid = 0; lsu_awid = 0; lsu_awlen = 0; lsu_awsize = 0; lsu_awburst = 0;
    lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0; lsu_wlast = 0;
    ic_rready = 1; lsu_rready = 1; lsu_bready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk) chk("reset_quiet", 64'(quiet()), 64'd0);
    rst_n_sync = 1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); chk("idle_quiet", 64'(quiet()), 64'd0); end

    // lone icache refill
    ar_q.push_back(addr_t(4'h1, 32'h3000_0040, 8'd7)); gap_q.push_back(0);
    ic_read(32'h3000_0040, 8'd7, 0);
    @(negedge clk) chk("post_refill_idle", 64'(quiet()), 64'd0);

    // tie with last_lsu = 0: LSU first, icache right after
    ar_q.push_back(addr_t(4'h2, 32'h1000_0100, 8'd0)); gap_q.push_back(0);
    ar_q.push_back(addr_t(4'h1, 32'h3000_0200, 8'd3)); gap_q.push_back(2);
    fork
      lsu_read(32'h1000_0100);
      ic_read(32'h3000_0200, 8'd3, 0);
    join

    // write with W two cycles after AW; concurrent icache waits for B
    @(negedge clk);
    ar_q.push_back(addr_t(4'h1, 32'h3000_0300, 8'd1)); gap_q.push_back(2);
    fork
      lsu_write(32'h8000_0010, 32'hDEAD_BEEF);
      ic_read(32'h3000_0300, 8'd1, 0);
    join

    // LSU read alone, then a tie goes to the icache
    @(negedge clk);
    ar_q.push_back(addr_t(4'h2, 32'h1000_0200, 8'd0)); gap_q.push_back(0);
    lsu_read(32'h1000_0200);
    @(negedge clk);
    ar_q.push_back(addr_t(4'h1, 32'h3000_0400, 8'd2)); gap_q.push_back(0);
    ar_q.push_back(addr_t(4'h2, 32'h1000_0300, 8'd0)); gap_q.push_back(2);
    fork
      ic_read(32'h3000_0400, 8'd2, 0);
      lsu_read(32'h1000_0300);
    join

    // backpressure after beat 3, error response on beat 4
    @(negedge clk);
    err_beat = 3;
    ar_q.push_back(addr_t(4'h1, 32'h3000_0500, 8'd7)); gap_q.push_back(0);
    ic_read(32'h3000_0500, 8'd7, 3);
    err_beat = 255;

    // reset during beat 3 of a refill
    @(negedge clk);
    ar_q.push_back(addr_t(4'h1, 32'h3000_0600, 8'd7)); gap_q.push_back(0);
    push_ic_beats(32'h3000_0600, 8'd7);
    ic_araddr = 32'h3000_0600; ic_arlen = 8'd7; ic_arid = 4'h1; ic_arsize = 3'd2; ic_arburst = 2'd1;
    ic_arvalid = 1;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin @(negedge clk); if (ic_arready) done = 1; end
    if (!done) flag("reset_test_ar_timeout");
    @(posedge clk); #1 ic_arvalid = 0;
    beats = 0;
    for (int t = 0; t < 300 && beats < 2; t++) begin @(negedge clk); if (ic_rvalid && ic_rready) beats++; end
    if (beats < 2) flag("reset_test_beat_timeout");
    @(posedge clk); #1 ic_rready = 0; rst_n_sync = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_quiet", 64'(quiet()), 64'd0);
    chk("reset_mid_ic_rdata", 64'(ic_rdata), 64'd0);
    ic_q.delete();
    slv_clr = 1;
    @(negedge clk);
    slv_clr = 0; rst_n_sync = 1; ic_rready = 1;
    @(negedge clk);
    ar_q.push_back(addr_t(4'h1, 32'h3000_0700, 8'd1)); gap_q.push_back(0);
    ic_read(32'h3000_0700, 8'd1, 0);

    repeat (5) @(negedge clk);
    chk("ar_q_left", 64'(ar_q.size()), 64'd0);
    chk("aw_q_left", 64'(aw_q.size()), 64'd0);
    chk("w_q_left", 64'(w_q.size()), 64'd0);
    chk("ic_q_left", 64'(ic_q.size()), 64'd0);
    chk("lsu_q_left", 64'(lsu_q.size()), 64'd0);
    chk("b_q_left", 64'(b_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
